// File: rtl/sonar_echo_emulator.sv
// rtl/sonar_echo_emulator.sv - HC-SR04 echo responder; define SONAR_EMU_HOLDOFF_EN for post-echo holdoff
module sonar_echo_emulator #(
    parameter int unsigned FREQ        = 50_000_000,
    parameter int unsigned MIN_TRIG_US = 10,
    parameter int unsigned BURST_US    = 200,
    parameter int unsigned US_PER_CM   = 58,
    parameter int unsigned MIN_CM      = 2,
    parameter int unsigned MAX_CM      = 400,
    parameter int unsigned NO_OBJ_US   = 38000,
    parameter int unsigned HOLDOFF_US  = 60000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trig,
    input  logic [8:0] dist_cm,
    input  logic       obj_present,
    output logic       echo,
    output logic       busy,
    output logic       trig_err
);

    localparam logic [31:0] CYC_PER_US   = 32'(FREQ / 1_000_000);
    localparam logic [31:0] MIN_TRIG_CYC = 32'(FREQ / 1_000_000 * MIN_TRIG_US);
    localparam logic [31:0] BURST_CYC    = 32'(FREQ / 1_000_000 * BURST_US);
    localparam logic [31:0] CM_CYC       = 32'(FREQ / 1_000_000 * US_PER_CM);
    localparam logic [31:0] NO_OBJ_CYC   = 32'(FREQ / 1_000_000 * NO_OBJ_US);
    localparam logic [31:0] MIN_CM_W     = 32'(MIN_CM);
    localparam logic [31:0] MAX_CM_W     = 32'(MAX_CM);
`ifdef SONAR_EMU_HOLDOFF_EN
    localparam logic [31:0] HOLDOFF_CYC  = 32'(FREQ / 1_000_000 * HOLDOFF_US);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG_HI,
        S_DELAY,
        S_ECHO
`ifdef SONAR_EMU_HOLDOFF_EN
        , S_HOLDOFF
`endif
    } state_t;

    state_t      state_q;
    logic        sync1_q;
    logic        trig_s_q;
    logic [31:0] cnt_q;
    logic [31:0] width_q;
    logic        echo_q;
    logic        busy_q;
    logic        trig_err_q;

    logic [31:0] dist_ext;
    logic [31:0] dist_clamped;
    logic [31:0] width_d;

    // Two-flop synchronizer for the asynchronous trig input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            trig_s_q <= 1'b0;
        end else begin
            sync1_q  <= trig;
            trig_s_q <= sync1_q;
        end
    end

    // Echo width for the live inputs; captured only when a measurement is accepted
    always_comb begin
        dist_ext = {23'd0, dist_cm};
        if (dist_ext < MIN_CM_W) begin
            dist_clamped = MIN_CM_W;
        end else if (dist_ext > MAX_CM_W) begin
            dist_clamped = MAX_CM_W;
        end else begin
            dist_clamped = dist_ext;
        end
        width_d = obj_present ? dist_clamped * CM_CYC : NO_OBJ_CYC;
    end

    // Measurement FSM; cnt_q is shared between trig width, burst delay, echo and holdoff timing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            width_q    <= '0;
            echo_q     <= 1'b0;
            busy_q     <= 1'b0;
            trig_err_q <= 1'b0;
        end else begin
            trig_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (trig_s_q) begin
                        state_q <= S_TRIG_HI;
                        cnt_q   <= 32'd1;
                        busy_q  <= 1'b1;
                    end
                end
                S_TRIG_HI: begin
                    if (trig_s_q) begin
                        if (cnt_q != 32'hFFFF_FFFF) cnt_q <= cnt_q + 32'd1;
                    end else if (cnt_q >= MIN_TRIG_CYC) begin
                        state_q <= S_DELAY;
                        cnt_q   <= '0;
                        width_q <= width_d;
                    end else begin
                        state_q    <= S_IDLE;
                        cnt_q      <= '0;
                        busy_q     <= 1'b0;
                        trig_err_q <= 1'b1;
                    end
                end
                S_DELAY: begin
                    // Entered one edge after trig_s falls, so BURST_CYC+1 edges here give BURST_CYC+3 from raw trig low
                    if (cnt_q == BURST_CYC) begin
                        state_q <= S_ECHO;
                        cnt_q   <= 32'd1;
                        echo_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_ECHO: begin
                    if (cnt_q >= width_q) begin
                        echo_q <= 1'b0;
`ifdef SONAR_EMU_HOLDOFF_EN
                        state_q <= S_HOLDOFF;
                        cnt_q   <= 32'd1;
`else
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
`ifdef SONAR_EMU_HOLDOFF_EN
                S_HOLDOFF: begin
                    if (cnt_q >= HOLDOFF_CYC) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    echo_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign echo     = echo_q;
    assign busy     = busy_q;
    assign trig_err = trig_err_q;

endmodule

// File: tb/tb_sonar_echo_emulator.sv
// tb/tb_sonar_echo_emulator.sv - scoreboard bench for sonar_echo_emulator
module tb_sonar_echo_emulator;

    localparam int BURST      = 200;
    localparam int LATENCY    = BURST + 3;
`ifdef SONAR_EMU_HOLDOFF_EN
    localparam bit HOLD       = 1'b1;
`else
    localparam bit HOLD       = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trig = 1'b0;
    logic [8:0] dist_cm = '0;
    logic       obj_present = 1'b0;
    logic       echo;
    logic       busy;
    logic       trig_err;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int trig_err_total = 0;

    sonar_echo_emulator #(.FREQ(1_000_000)) dut (
        .clk(clk), .rst_n(rst_n), .trig(trig), .dist_cm(dist_cm),
        .obj_present(obj_present), .echo(echo), .busy(busy), .trig_err(trig_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (trig_err) trig_err_total++;
    end

    function automatic int model_width(input int d, input bit obj);
        int c;
        c = (d < 2) ? 2 : ((d > 400) ? 400 : d);
        return obj ? c * 58 : 38000;
    endfunction

    task automatic pulse_trig(input int n);
        @(posedge clk);
        #1 trig = 1'b1;
        repeat (n) @(posedge clk);
        #1 trig = 1'b0;
    endtask

    // lat counts edges after the first edge that samples trig low; width counts high samples
    task automatic measure(output int lat, output int width, output bit ok);
        lat = -1;
        width = 0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (echo) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        ok = 1'b0;
        width = 1;
        for (int i = 0; i < 60000; i++) begin
            @(posedge clk);
            #1;
            if (!echo) begin
                ok = 1'b1;
                break;
            end
            width++;
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            errors++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", limit);
        end
        checks++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #22;
        checks++; if (echo !== 1'b0) begin errors++; $display("FAIL reset_echo: got %b expected 0", echo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (trig_err !== 1'b0) begin errors++; $display("FAIL reset_trig_err: got %b expected 0", trig_err); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic run_measurement(input string name, input int d, input bit obj, input int n);
        int lat, w, exp_w, err0;
        bit ok;
        dist_cm = 9'(d);
        obj_present = obj;
        err0 = trig_err_total;
        exp_q.push_back(model_width(d, obj));
        pulse_trig(n);
        measure(lat, w, ok);
        exp_w = exp_q.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL %s_timeout: echo pulse not completed", name); end
        checks++; if (lat !== LATENCY) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, LATENCY); end
        checks++; if (w !== exp_w) begin errors++; $display("FAIL %s_width: got %0d expected %0d", name, w, exp_w); end
        checks++; if (busy !== HOLD) begin errors++; $display("FAIL %s_busy_at_fall: got %b expected %b", name, busy, HOLD); end
        checks++; if (trig_err_total !== err0) begin errors++; $display("FAIL %s_trig_err: got %0d pulses expected 0", name, trig_err_total - err0); end
    endtask

    task automatic test_basic();
        wait_idle(70000);
        run_measurement("basic", 100, 1'b1, 12);
    endtask

    task automatic test_no_obj();
        wait_idle(70000);
        run_measurement("no_obj", 100, 1'b0, 10);
    endtask

    task automatic test_short_trig();
        int err0, echo_seen;
        wait_idle(70000);
        dist_cm = 9'd100;
        obj_present = 1'b1;
        err0 = trig_err_total;
        echo_seen = 0;
        pulse_trig(9);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (echo) echo_seen++;
        end
        checks++; if (trig_err_total - err0 !== 1) begin errors++; $display("FAIL short_trig_err: got %0d pulses expected 1", trig_err_total - err0); end
        checks++; if (echo_seen !== 0) begin errors++; $display("FAIL short_trig_echo: got %0d high cycles expected 0", echo_seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_trig_busy: got %b expected 0", busy); end
    endtask

    task automatic test_clamp();
        int lat, w, exp_w;
        bit ok;
        wait_idle(70000);
        run_measurement("clamp_low", 0, 1'b1, 12);
        wait_idle(70000);
        dist_cm = 9'd450;
        obj_present = 1'b1;
        exp_q.push_back(model_width(450, 1'b1));
        pulse_trig(12);
        fork
            measure(lat, w, ok);
            begin
                repeat (50) @(posedge clk);
                #1 dist_cm = 9'd50;
            end
        join
        exp_w = exp_q.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL clamp_high_timeout: echo pulse not completed"); end
        checks++; if (w !== exp_w) begin errors++; $display("FAIL clamp_high_width: got %0d expected %0d", w, exp_w); end
    endtask

    task automatic test_ignore_retrig();
        int lat, w, exp_w, err0;
        bit ok;
        wait_idle(70000);
        dist_cm = 9'd20;
        obj_present = 1'b1;
        err0 = trig_err_total;
        exp_q.push_back(model_width(20, 1'b1));
        pulse_trig(12);
        fork
            measure(lat, w, ok);
            begin
                repeat (50) @(posedge clk);
                pulse_trig(15);
                repeat (300) @(posedge clk);
                pulse_trig(15);
            end
        join
        exp_w = exp_q.pop_front();
        checks++; if (lat !== LATENCY) begin errors++; $display("FAIL retrig_latency: got %0d expected %0d", lat, LATENCY); end
        checks++; if (w !== exp_w || !ok) begin errors++; $display("FAIL retrig_width: got %0d expected %0d", w, exp_w); end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (busy !== HOLD) begin errors++; $display("FAIL retrig_no_restart: busy %b expected %b", busy, HOLD); end
        checks++; if (trig_err_total !== err0) begin errors++; $display("FAIL retrig_trig_err: got %0d pulses expected 0", trig_err_total - err0); end
    endtask

    task automatic test_reset_mid_echo();
        bit seen;
        wait_idle(70000);
        dist_cm = 9'd100;
        obj_present = 1'b1;
        exp_q.push_back(model_width(100, 1'b1));
        pulse_trig(12);
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (echo) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rst_mid_echo_start: echo never rose"); end
        repeat (100) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        // the aborted pulse will never complete, so its expectation is dropped
        exp_q.delete();
        checks++; if (echo !== 1'b0) begin errors++; $display("FAIL rst_mid_echo_echo: got %b expected 0", echo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_echo_busy: got %b expected 0", busy); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || echo !== 1'b0) begin errors++; $display("FAIL rst_mid_echo_idle: busy %b echo %b expected 0 0", busy, echo); end
    endtask

    task automatic test_back_to_back();
        int lat, w, exp_w;
        bit ok;
        wait_idle(70000);
        run_measurement("b2b_first", 10, 1'b1, 12);
        repeat (4) @(posedge clk);
`ifdef SONAR_EMU_HOLDOFF_EN
        begin
            int echo_seen;
            echo_seen = 0;
            #1;
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL holdoff_busy: got %b expected 1", busy); end
            pulse_trig(12);
            for (int i = 0; i < 1000; i++) begin
                @(posedge clk);
                #1;
                if (echo) echo_seen++;
            end
            checks++; if (echo_seen !== 0) begin errors++; $display("FAIL holdoff_ignore: got %0d echo cycles expected 0", echo_seen); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL holdoff_busy_late: got %b expected 1", busy); end
            wait_idle(70000);
        end
`endif
        dist_cm = 9'd10;
        exp_q.push_back(model_width(10, 1'b1));
        pulse_trig(12);
        measure(lat, w, ok);
        exp_w = exp_q.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL b2b_second_timeout: echo pulse not completed"); end
        checks++; if (lat !== LATENCY) begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, LATENCY); end
        checks++; if (w !== exp_w) begin errors++; $display("FAIL b2b_second_width: got %0d expected %0d", w, exp_w); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_obj();
        test_short_trig();
        test_clamp();
        test_ignore_retrig();
        test_reset_mid_echo();
        test_back_to_back();
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_empty: %0d entries left expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
